// File: rtl/alu_int_base_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined integer base ALU.
package alu_int_base_pkg;

  localparam int ALU_INT_OP_W = 5;

  // Bit positions within flags[3:0] = {N,Z,C,V}
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [ALU_INT_OP_W-1:0] {
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_NOT  = 5'd5,
    OP_XOR  = 5'd6,
    OP_SHL  = 5'd7,
    OP_SHR  = 5'd8,
    OP_SAR  = 5'd9,
    OP_BAND = 5'd10,
    OP_BOR  = 5'd11,
    OP_BNOT = 5'd12,
    OP_EQ   = 5'd13,
    OP_NE   = 5'd14,
    OP_GT_S = 5'd15,
    OP_GE_S = 5'd16,
    OP_LT_S = 5'd17,
    OP_LE_S = 5'd18,
    OP_GT_U = 5'd19,
    OP_GE_U = 5'd20,
    OP_LT_U = 5'd21,
    OP_LE_U = 5'd22
  } alu_int_op_e;

endpackage

// File: rtl/alu_int_base_core.sv
// Combinational compute stage: opcode + operands -> result, illegal flag and (optionally)
// NZCV flags. Flags exist only when ALU_INT_BASE_FLAGS_EN is defined.
module alu_int_base_core
  import alu_int_base_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [ALU_INT_OP_W-1:0] op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic [WIDTH-1:0]        result,
  output logic                    illegal
`ifdef ALU_INT_BASE_FLAGS_EN
  ,
  output logic [3:0]              flags
`endif
);

  logic [WIDTH-1:0] sum, diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Shifts with amount >= WIDTH naturally give 0 / sign fill, so no masking of b.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b;
      OP_SHR:  result = a >> b;
      OP_SAR:  result = $signed(a) >>> b;
      OP_BAND: result = WIDTH'((a != '0) && (b != '0));
      OP_BOR:  result = WIDTH'((a != '0) || (b != '0));
      OP_BNOT: result = WIDTH'(b == '0);
      OP_EQ:   result = WIDTH'(a == b);
      OP_NE:   result = WIDTH'(a != b);
      OP_GT_S: result = WIDTH'($signed(a) >  $signed(b));
      OP_GE_S: result = WIDTH'($signed(a) >= $signed(b));
      OP_LT_S: result = WIDTH'($signed(a) <  $signed(b));
      OP_LE_S: result = WIDTH'($signed(a) <= $signed(b));
      OP_GT_U: result = WIDTH'(a >  b);
      OP_GE_U: result = WIDTH'(a >= b);
      OP_LT_U: result = WIDTH'(a <  b);
      OP_LE_U: result = WIDTH'(a <= b);
      default: illegal = 1'b1;
    endcase
  end

`ifdef ALU_INT_BASE_FLAGS_EN
  always_comb begin
    flags = '0;
    if (!illegal) begin
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = (result == '0);
      if (op == OP_ADD) begin
        flags[FLAG_C] = (sum < a);  // wrapped sum below an operand means carry-out
        flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end else if (op == OP_SUB) begin
        flags[FLAG_C] = (a < b);
        flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_int_base_pipe.sv
// Pipelined integer base ALU: one op per cycle, result LATENCY cycles later, clean flush.
// Optional NZCV flags output when ALU_INT_BASE_FLAGS_EN is defined.
module alu_int_base_pipe
  import alu_int_base_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clean,
  input  logic                    start,
  input  logic [WIDTH-1:0]        numA,
  input  logic [WIDTH-1:0]        numB,
  input  logic [ALU_INT_OP_W-1:0] funcSelect,
  output logic [WIDTH-1:0]        numC,
  output logic                    isNowTickReady,
  output logic                    isInvailFuncSelect
`ifdef ALU_INT_BASE_FLAGS_EN
  ,
  output logic [3:0]              flags
`endif
);

  logic [WIDTH-1:0]              res0;
  logic                          ill0;
  logic                          issue;
  logic [LATENCY:1]              vld_pipe;
  logic [LATENCY:1]              ill_pipe;
  logic [LATENCY:1][WIDTH-1:0]   data_pipe;
`ifdef ALU_INT_BASE_FLAGS_EN
  logic [3:0]                    flg0;
  logic [LATENCY:1][3:0]         flg_pipe;
`endif

  alu_int_base_core #(.WIDTH(WIDTH)) u_core (
    .op      (funcSelect),
    .a       (numA),
    .b       (numB),
    .result  (res0),
    .illegal (ill0)
`ifdef ALU_INT_BASE_FLAGS_EN
    ,
    .flags   (flg0)
`endif
  );

  // clean beats a same-cycle start
  assign issue = start & ~clean;

  // Data registers only load behind a valid bit, and not while flushing, so numC
  // keeps the last completed result through bubbles and flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      ill_pipe  <= '0;
      data_pipe <= '0;
`ifdef ALU_INT_BASE_FLAGS_EN
      flg_pipe  <= '0;
`endif
    end else begin
      vld_pipe[1] <= issue;
      if (issue) begin
        data_pipe[1] <= res0;
        ill_pipe[1]  <= ill0;
`ifdef ALU_INT_BASE_FLAGS_EN
        flg_pipe[1]  <= flg0;
`endif
      end
      for (int s = 2; s <= LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1] & ~clean;
        if (vld_pipe[s-1] && !clean) begin
          data_pipe[s] <= data_pipe[s-1];
          ill_pipe[s]  <= ill_pipe[s-1];
`ifdef ALU_INT_BASE_FLAGS_EN
          flg_pipe[s]  <= flg_pipe[s-1];
`endif
        end
      end
    end
  end

  assign numC               = data_pipe[LATENCY];
  assign isNowTickReady     = vld_pipe[LATENCY];
  assign isInvailFuncSelect = vld_pipe[LATENCY] & ill_pipe[LATENCY];
`ifdef ALU_INT_BASE_FLAGS_EN
  assign flags              = flg_pipe[LATENCY];
`endif

endmodule

// File: tb/tb_alu_int_base_pipe.sv
// Directed bench for alu_int_base_pipe: a 64-bit/latency-2 instance and an 8-bit/latency-1 one.
module tb_alu_int_base_pipe;

  logic        clk = 1'b0;
  logic        rst, clean, start64, start8;
  logic [63:0] numA, numB;
  logic [4:0]  funcSelect;
  logic [63:0] c64;
  logic [7:0]  c8;
  logic        rdy64, inv64, rdy8, inv8;
  logic [3:0]  flags64, flags8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_int_base_pipe #(.WIDTH(64), .LATENCY(2)) u_dut64 (
    .clk(clk), .rst(rst), .clean(clean), .start(start64),
    .numA(numA), .numB(numB), .funcSelect(funcSelect),
    .numC(c64), .isNowTickReady(rdy64), .isInvailFuncSelect(inv64)
`ifdef ALU_INT_BASE_FLAGS_EN
    , .flags(flags64)
`endif
  );

  alu_int_base_pipe #(.WIDTH(8), .LATENCY(1)) u_dut8 (
    .clk(clk), .rst(rst), .clean(clean), .start(start8),
    .numA(numA[7:0]), .numB(numB[7:0]), .funcSelect(funcSelect),
    .numC(c8), .isNowTickReady(rdy8), .isInvailFuncSelect(inv8)
`ifdef ALU_INT_BASE_FLAGS_EN
    , .flags(flags8)
`endif
  );

`ifndef ALU_INT_BASE_FLAGS_EN
  assign flags64 = '0;
  assign flags8  = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op on the selected instance and check the pulse, the result and the hold after.
  task automatic run(input string tag, input bit s8, input logic [4:0] op,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] ec, input logic ei, input logic [3:0] ef);
    int lat;
    lat = s8 ? 1 : 2;
    @(negedge clk);
    funcSelect = op; numA = a; numB = b;
    if (s8) start8 = 1'b1; else start64 = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      start64 = 1'b0; start8 = 1'b0;
      if (k < lat) chk({tag, "_early"}, {63'd0, rdy64}, 64'd0);
    end
    chk({tag, "_rdy"}, {63'd0, s8 ? rdy8 : rdy64}, 64'd1);
    chk({tag, "_c"}, s8 ? {56'd0, c8} : c64, ec);
    chk({tag, "_inv"}, {63'd0, s8 ? inv8 : inv64}, {63'd0, ei});
`ifdef ALU_INT_BASE_FLAGS_EN
    chk({tag, "_flg"}, {60'd0, s8 ? flags8 : flags64}, {60'd0, ef});
`endif
    @(negedge clk);
    chk({tag, "_hold_rdy"}, {63'd0, s8 ? rdy8 : rdy64}, 64'd0);
    chk({tag, "_hold_c"}, s8 ? {56'd0, c8} : c64, ec);
    chk({tag, "_hold_inv"}, {63'd0, s8 ? inv8 : inv64}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; clean = 1'b0; start64 = 1'b0; start8 = 1'b0;
    numA = '0; numB = '0; funcSelect = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {63'd0, rdy64}, 64'd0);
    chk("rst_c", c64, 64'd0);
    chk("rst_inv", {63'd0, inv64}, 64'd0);
    chk("rst_flg", {60'd0, flags64}, 64'd0);
    chk("rst_c8", {56'd0, c8}, 64'd0);
    rst = 1'b0;

    // Flags encoded {N,Z,C,V}
    run("add_wrap", 0, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 4'b0110);
    run("sub_ovf",  0, 5'd2,  64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'b0001);
    run("sar_64",   0, 5'd9,  64'h8000_0000_0000_0000, 64'd64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b1000);
    run("shr_64",   0, 5'd8,  64'h8000_0000_0000_0000, 64'd64, 64'd0, 0, 4'b0100);
    run("shl_63",   0, 5'd7,  64'd1, 64'd63, 64'h8000_0000_0000_0000, 0, 4'b1000);
    run("shl_huge", 0, 5'd7,  64'd1, 64'h8000_0000_0000_0000, 64'd0, 0, 4'b0100);
    run("lt_s",     0, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 0, 4'b0000);
    run("lt_u",     0, 5'd21, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 0, 4'b0100);
    run("ge_s",     0, 5'd16, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 4'b0000);
    run("eq",       0, 5'd13, 64'd5, 64'd5, 64'd1, 0, 4'b0000);
    run("and",      0, 5'd3,  64'hF0, 64'h3C, 64'h30, 0, 4'b0000);
    run("not",      0, 5'd5,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b1000);
    run("bnot",     0, 5'd12, 64'd7, 64'd0, 64'd1, 0, 4'b0000);
    run("ill_0",    0, 5'd0,  64'd9, 64'd9, 64'd0, 1, 4'b0000);
    run("ill_23",   0, 5'd23, 64'd9, 64'd9, 64'd0, 1, 4'b0000);

    // Four back-to-back ADDs; clean on the third issue cycle flushes ops 2 and 3.
    @(negedge clk); funcSelect = 5'd1; numA = 64'd1; numB = 64'd2; start64 = 1'b1;
    @(negedge clk); numA = 64'd10; numB = 64'd10;
    @(negedge clk);
    chk("cl_op1_rdy", {63'd0, rdy64}, 64'd1);
    chk("cl_op1_c", c64, 64'd3);
    numA = 64'd5; numB = 64'd5; clean = 1'b1;
    @(negedge clk);
    chk("cl_op2_rdy", {63'd0, rdy64}, 64'd0);
    chk("cl_op2_c", c64, 64'd3);
    numA = 64'd7; numB = 64'd7; clean = 1'b0;
    @(negedge clk); start64 = 1'b0;
    chk("cl_op3_rdy", {63'd0, rdy64}, 64'd0);
    chk("cl_op3_c", c64, 64'd3);
    @(negedge clk);
    chk("cl_op4_rdy", {63'd0, rdy64}, 64'd1);
    chk("cl_op4_c", c64, 64'd14);
    @(negedge clk);
    chk("cl_after_rdy", {63'd0, rdy64}, 64'd0);

    // Reset while an op is mid-pipe: nothing may emerge after release.
    @(negedge clk); funcSelect = 5'd1; numA = 64'd2; numB = 64'd2; start64 = 1'b1;
    @(negedge clk); start64 = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_rdy", {63'd0, rdy64}, 64'd0);
    chk("mrst_c", c64, 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mrst_nopulse", {63'd0, rdy64}, 64'd0);
      chk("mrst_c_hold", c64, 64'd0);
    end

    // 8-bit, latency-1 instance
    run("w8_add",  1, 5'd1, 64'hFF, 64'h02, 64'h01, 0, 4'b0010);
    run("w8_sar",  1, 5'd9, 64'h80, 64'h08, 64'hFF, 0, 4'b1000);
    run("w8_shl",  1, 5'd7, 64'h01, 64'hC8, 64'h00, 0, 4'b0100);
    run("w8_sub",  1, 5'd2, 64'h80, 64'h01, 64'h7F, 0, 4'b0001);
    run("w8_ill",  1, 5'd31, 64'h01, 64'h01, 64'h00, 1, 4'b0000);

    // Start coincident with reset on the latency-1 instance must not pulse.
    @(negedge clk); funcSelect = 5'd1; numA = 64'd1; numB = 64'd1; start8 = 1'b1; rst = 1'b1;
    @(negedge clk); start8 = 1'b0; rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("w8_rst_nopulse", {63'd0, rdy8}, 64'd0);
      chk("w8_rst_c", {56'd0, c8}, 64'd0);
    end
    run("w8_after", 1, 5'd1, 64'd3, 64'd4, 64'd7, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
